// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   Instruction-fetch front end. Owns the fetch PC, issues in-order word
//   fetches to instruction memory, and buffers the in-order responses in a
//   DEPTH-entry circular queue. The decode stage drains it through a
//   valid/ready handshake. A redirect flushes the queue, counts the responses
//   still in flight so they are discarded on arrival, and restarts fetch.
//
// Parameters
//   DEPTH     queue entries and maximum requests in flight (power of two, >= 2)
//   RESET_PC  fetch address after reset
//
// Ports
//   clk, reset                  clock; asynchronous active-high reset
//   imem_req_valid/ready/addr   fetch request channel (word-aligned address)
//   imem_rsp_valid/data         in-order response; never backpressured
//   redirect_valid/pc           one-cycle flush and restart at redirect_pc
//   id_valid/ready/instr/pc     head instruction and its PC towards decode
//
// Build option
//   IF_QUEUE_BYPASS_EN  when defined, a response landing in an empty head
//                       entry is forwarded to id_* in the same cycle.
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 2;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  logic [PW:0]   head_ptr, tail_ptr, fill_ptr;
  logic [PW:0]   drop_cnt;
  logic [31:0]   fetch_pc;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];

  logic [PW-1:0] head_idx, tail_idx, fill_idx;
  logic [PW:0]   alloc_cnt, unfilled_cnt, rsp_cnt;
  logic [CW-1:0] used_cnt;
  logic          credit, accept, rsp_drop, rsp_fill, head_filled, pop;

  assign head_idx     = head_ptr[PW-1:0];
  assign tail_idx     = tail_ptr[PW-1:0];
  assign fill_idx     = fill_ptr[PW-1:0];
  assign alloc_cnt    = tail_ptr - head_ptr;
  assign unfilled_cnt = tail_ptr - fill_ptr;
  assign rsp_cnt      = {{PW{1'b0}}, imem_rsp_valid};

  // Stale responses still owed by memory occupy credit just like live
  // entries, which guarantees every response has somewhere to land.
  assign used_cnt = CW'(alloc_cnt) + CW'(drop_cnt);
  assign credit   = used_cnt < CW'(DEPTH);

  // Gating with reset keeps the request quiet while reset is held; a redirect
  // withdraws any pending request so the old stream never gets another beat.
  assign imem_req_valid = !reset && credit && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_drop    = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill    = imem_rsp_valid && (drop_cnt == '0);
  assign head_filled = head_ptr != fill_ptr;

`ifdef IF_QUEUE_BYPASS_EN
  logic byp;
  // Head not yet filled but its response is arriving right now.
  assign byp = rsp_fill && !head_filled;
`endif

  always_comb begin
    id_valid = head_filled;
    id_instr = head_filled ? q_instr[head_idx] : '0;
`ifdef IF_QUEUE_BYPASS_EN
    if (byp) begin
      id_valid = 1'b1;
      id_instr = imem_rsp_data;
    end
`endif
    id_pc = id_valid ? q_pc[head_idx] : '0;
  end

  // A pop coinciding with a redirect belongs to the flushed stream.
  assign pop = id_valid && id_ready && !redirect_valid;

  // Control state: pointers, drop counter, fetch PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      drop_cnt <= '0;
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      // Everything in flight (already owed plus unfilled entries) becomes
      // stale, minus the response retiring in this very cycle.
      head_ptr <= tail_ptr;
      fill_ptr <= tail_ptr;
      drop_cnt <= drop_cnt + unfilled_cnt - rsp_cnt;
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (accept) begin
        tail_ptr <= tail_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      if (rsp_fill) fill_ptr <= fill_ptr + 1'b1;
      if (pop)      head_ptr <= head_ptr + 1'b1;
    end
  end

  // Queue payload: only read when the matching pointers say it is valid.
  always_ff @(posedge clk) begin
    if (accept) q_pc[tail_idx] <= fetch_pc;
    if (rsp_fill && !redirect_valid) q_instr[fill_idx] <= imem_rsp_data;
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_QUEUE_BYPASS_EN
  localparam int ID_LAT = 1;
`else
  localparam int ID_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct packed { logic [31:0] addr; int t; } req_t;
  req_t        pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr = RESET_PC;
  int          mem_lat = 1;
  int          acc_cnt, pop_cnt, first_acc, first_id, first_pop, last_pop, rel_cyc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: fixed latency mem_lat, in order, one response per cycle.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && pend.size() > 0 && cyc >= pend[0].t + mem_lat) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: request addresses and decode-side scoreboard.
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (!reset) begin
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
        pend.push_back('{addr: imem_req_addr, t: cyc});
      end
      if (id_valid && first_id < 0) first_id = cyc;
      if (id_valid && id_ready && !redirect_valid) begin
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL id_unexpected: got pc %h, required no output", id_pc);
        end else begin
          e = exp_q.pop_front();
          check("id_pc", id_pc, e);
          check("id_instr", id_instr, instr_of(e));
        end
      end
    end
  end

  // Called just after a rising edge; reset takes effect without a clock.
  task automatic do_reset();
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pend.delete();
    exp_q.delete();
    exp_addr = RESET_PC;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_instr", id_instr, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    tick(2);
    acc_cnt = 0; pop_cnt = 0;
    first_acc = -1; first_id = -1; first_pop = -1; last_pop = -1;
    reset   = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d entries outstanding, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    imem_req_ready = 1'b0; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick(1);

    // Streaming, 1-cycle memory, decode always ready.
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    wait_drain("s1", 40);
    id_ready = 1'b0; imem_req_ready = 1'b0;
    check("s1_first_req_cycle", 32'(first_acc), 32'(rel_cyc));
    check("s1_id_latency", 32'(first_id - first_acc), 32'(ID_LAT));
    check("s1_throughput", 32'(last_pop - first_pop), 32'd7);

    // Decode stalled: queue fills after exactly DEPTH accepts.
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
    tick(10);
    check("s2_accepts_when_full", 32'(acc_cnt), 32'd4);
    check("s2_req_valid_full", 32'(imem_req_valid), 32'd0);
    exp_q.push_back(32'h00); exp_q.push_back(32'h04);
    exp_q.push_back(32'h08); exp_q.push_back(32'h0C);
    exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    id_ready = 1'b1;
    wait_drain("s2", 40);
    id_ready = 1'b0; imem_req_ready = 1'b0;
    check("s2_resumed", 32'(acc_cnt >= 6), 32'd1);

    // Memory not ready for 3 cycles: request must hold steady.
    do_reset();
    mem_lat = 1; id_ready = 1'b1; imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s3_hold_valid", 32'(imem_req_valid), 32'd1);
      check("s3_hold_addr", imem_req_addr, 32'h0);
      tick(1);
    end
    imem_req_ready = 1'b1;
    exp_q.push_back(32'h0);
    tick(1);
    imem_req_ready = 1'b0;
    wait_drain("s3", 20);
    tick(4);
    check("s3_accepts", 32'(acc_cnt), 32'd1);
    check("s3_pops", 32'(pop_cnt), 32'd1);

    // Redirect with three requests outstanding.
    do_reset();
    mem_lat = 4; id_ready = 1'b1; imem_req_ready = 1'b0;
    tick(1);
    redirect_valid = 1'b1; redirect_pc = 32'h20; exp_addr = 32'h20;
    tick(1);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    tick(3);
    check("s4_outstanding", 32'(acc_cnt), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h103; exp_addr = 32'h100;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    tick(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("s4_redirect_req_valid", 32'(imem_req_valid), 32'd1);
    check("s4_redirect_req_addr", imem_req_addr, 32'h100);
    wait_drain("s4", 40);
    id_ready = 1'b0; imem_req_ready = 1'b0;

    // Redirect coincident with a response and a decode-ready, 2 entries filled.
    do_reset();
    mem_lat = 1; id_ready = 1'b0; imem_req_ready = 1'b1;
    tick(3);
    imem_req_ready = 1'b0; id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h200; exp_addr = 32'h200;
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    @(negedge clk);
    check("s5_setup_rsp", 32'(imem_rsp_valid), 32'd1);
    check("s5_setup_id_valid", 32'(id_valid), 32'd1);
    tick(1);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    check("s5_flushed_id_valid", 32'(id_valid), 32'd0);
    check("s5_redirect_req_addr", imem_req_addr, 32'h200);
    wait_drain("s5", 30);
    id_ready = 1'b0; imem_req_ready = 1'b0;

    // Reset while credit is exhausted with two stale responses owed.
    do_reset();
    mem_lat = 8; id_ready = 1'b0; imem_req_ready = 1'b1;
    tick(2);
    redirect_valid = 1'b1; redirect_pc = 32'h300; exp_addr = 32'h300;
    tick(1);
    redirect_valid = 1'b0;
    tick(2);
    @(negedge clk);
    check("s6_credit_full", 32'(imem_req_valid), 32'd0);
    check("s6_accepts", 32'(acc_cnt), 32'd4);
    check("s6_addr_before_reset", imem_req_addr, 32'h308);
    tick(1);
    do_reset();
    mem_lat = 1; id_ready = 1'b1; imem_req_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    wait_drain("s6", 30);
    id_ready = 1'b0; imem_req_ready = 1'b0;
    check("s6_restart_cycle", 32'(first_acc), 32'(rel_cyc));

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
